// File: rtl/inst_sram_resp.sv
// Instruction RAM responder for the Fetch-side inst_sram port: word array, byte-lane writes,
// 1-cycle read latency, NOP fill sweep after reset and a side loader port.
module inst_sram_resp #(
  parameter int unsigned ADDR_W    = 14,
  parameter logic [31:0] BASE_ADDR = 32'h1c00_0000,
  parameter logic [31:0] FILL_WORD = 32'h0340_0000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              inst_sram_en,
  input  logic [3:0]        inst_sram_we,
  input  logic [31:0]       inst_sram_addr,
  input  logic [31:0]       inst_sram_wdata,
  output logic [31:0]       inst_sram_rdata,
  output logic              rdata_valid,
  output logic              addr_err,
  output logic              init_done,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_idx,
  input  logic [31:0]       ld_data
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
  logic [31:0]       mem [DEPTH];
  logic [31:0]       rdata_q;
  logic              rdata_valid_q;
  logic              addr_err_q;

  logic              sweep;
  logic              run;
  logic              in_range;
  logic [ADDR_W-1:0] idx;
  logic              bus_rd;
  logic              bus_wr;
  logic              ld_wr;
  logic              unused_addr_lsb;

  // Byte offset within a word plays no part in the lookup.
  assign unused_addr_lsb = ^inst_sram_addr[1:0];

  assign in_range = inst_sram_addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2];
  assign idx      = inst_sram_addr[ADDR_W+1:2];
  assign bus_rd   = run & inst_sram_en & (inst_sram_we == 4'b0000);
  assign bus_wr   = run & inst_sram_en & (|inst_sram_we) & in_range;
  assign ld_wr    = run & ld_en;

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= StInit;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    unique case (state_q)
      StInit: begin
        init_cnt_d = init_cnt_q + ADDR_W'(1);
        if (&init_cnt_q) begin
          state_d = StRun;
        end
      end
      StRun: state_d = StRun;
      default: state_d = StInit;
    endcase
  end

  // FSM outputs; nothing touches the array while reset is held.
  always_comb begin
    sweep     = 1'b0;
    run       = 1'b0;
    init_done = 1'b0;
    unique case (state_q)
      StInit: sweep = rstn;
      StRun: begin
        run       = rstn;
        init_done = 1'b1;
      end
      default: sweep = 1'b0;
    endcase
  end

  // Loader assignment comes last so it overrides a same-index bus write on every lane.
  always_ff @(posedge clk) begin
    if (sweep) begin
      mem[init_cnt_q] <= FILL_WORD;
    end else begin
      if (bus_wr) begin
        for (int k = 0; k < 4; k++) begin
          if (inst_sram_we[k]) begin
            mem[idx][8*k +: 8] <= inst_sram_wdata[8*k +: 8];
          end
        end
      end
      if (ld_wr) begin
        mem[ld_idx] <= ld_data;
      end
    end
  end

  // Read-first: the old array contents are sampled at the same edge any write lands.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rdata_q       <= FILL_WORD;
      rdata_valid_q <= 1'b0;
      addr_err_q    <= 1'b0;
    end else begin
      rdata_valid_q <= bus_rd;
      addr_err_q    <= bus_rd & ~in_range;
      if (bus_rd) begin
        rdata_q <= in_range ? mem[idx] : FILL_WORD;
      end
    end
  end

  assign inst_sram_rdata = rdata_q;
  assign rdata_valid     = rdata_valid_q;
  assign addr_err        = addr_err_q;

endmodule

// File: tb/tb_inst_sram_resp.sv
// Directed bench for inst_sram_resp; read responses are checked against a due-cycle scoreboard.
module tb_inst_sram_resp;

  localparam int unsigned AW    = 14;
  localparam int unsigned DEPTH = 2 ** AW;
  localparam logic [31:0] FILL  = 32'h0340_0000;
  localparam logic [31:0] BASE  = 32'h1c00_0000;

  typedef struct {
    int          due;
    logic [31:0] d;
    logic        e;
  } rsp_t;

  logic          clk;
  logic          rstn;
  logic          en;
  logic [3:0]    we;
  logic [31:0]   addr;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic          rdata_valid;
  logic          addr_err;
  logic          init_done;
  logic          ld_en;
  logic [AW-1:0] ld_idx;
  logic [31:0]   ld_data;

  int   total;
  int   bad;
  int   cyc;
  rsp_t q[$];

  inst_sram_resp #(
    .ADDR_W   (AW),
    .BASE_ADDR(BASE),
    .FILL_WORD(FILL)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .inst_sram_en   (en),
    .inst_sram_we   (we),
    .inst_sram_addr (addr),
    .inst_sram_wdata(wdata),
    .inst_sram_rdata(rdata),
    .rdata_valid    (rdata_valid),
    .addr_err       (addr_err),
    .init_done      (init_done),
    .ld_en          (ld_en),
    .ld_idx         (ld_idx),
    .ld_data        (ld_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic e, input logic [3:0] w, input logic [31:0] a,
                     input logic [31:0] wd, input logic le, input logic [AW-1:0] li,
                     input logic [31:0] ld);
    @(negedge clk);
    en      = e;
    we      = w;
    addr    = a;
    wdata   = wd;
    ld_en   = le;
    ld_idx  = li;
    ld_data = ld;
  endtask

  task automatic expect_rsp(input logic [31:0] d, input logic e);
    q.push_back('{cyc + 1, d, e});
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] d, input logic e);
    drv(1'b1, 4'b0000, a, 32'd0, 1'b0, '0, 32'd0);
    expect_rsp(d, e);
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] w, input logic [31:0] wd);
    drv(1'b1, w, a, wd, 1'b0, '0, 32'd0);
  endtask

  task automatic ld(input logic [AW-1:0] li, input logic [31:0] d);
    drv(1'b0, 4'b0000, 32'd0, 32'd0, 1'b1, li, d);
  endtask

  task automatic idle();
    drv(1'b0, 4'b0000, 32'd0, 32'd0, 1'b0, '0, 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rdata"}, rdata, FILL);
    chk({tag, "_valid"}, 32'(rdata_valid), 32'd0);
    chk({tag, "_err"}, 32'(addr_err), 32'd0);
    chk({tag, "_init_done"}, 32'(init_done), 32'd0);
  endtask

  initial begin
    rsp_t r;
    rstn    = 1'b0;
    en      = 1'b0;
    we      = 4'b0000;
    addr    = 32'd0;
    wdata   = 32'd0;
    ld_en   = 1'b0;
    ld_idx  = '0;
    ld_data = 32'd0;
    total   = 0;
    bad     = 0;

    // Response monitor: a response is due exactly one cycle after its request.
    fork
      forever begin
        @(negedge clk);
        if (q.size() > 0 && q[0].due == cyc) begin
          r = q.pop_front();
          chk("rsp_valid", 32'(rdata_valid), 32'd1);
          chk("rsp_rdata", rdata, r.d);
          chk("rsp_err", 32'(addr_err), 32'(r.e));
        end else begin
          chk("no_valid", 32'(rdata_valid), 32'd0);
          chk("no_err", 32'(addr_err), 32'd0);
        end
      end
    join_none

    // T1: reset values, init sweep length, first read
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rstn = 1'b1;
    repeat (DEPTH - 1) @(negedge clk);
    chk("init_done_early", 32'(init_done), 32'd0);
    @(negedge clk);
    chk("init_done_rise", 32'(init_done), 32'd1);
    rd(BASE, FILL, 1'b0);

    // T2: loader preload, back-to-back reads
    for (int i = 0; i < 4; i++) ld(AW'(i), 32'h1111_1111 * 32'(i + 1));
    for (int i = 0; i < 4; i++) rd(BASE + 32'(4 * i), 32'h1111_1111 * 32'(i + 1), 1'b0);
    idle();

    // T3: byte-lane write, rdata holds across the write
    wr(BASE, 4'b0101, 32'haabb_ccdd);
    idle();
    chk("hold_after_wr", rdata, 32'h4444_4444);
    rd(BASE, 32'h11bb_11dd, 1'b0);
    rd(BASE + 32'd3, 32'h11bb_11dd, 1'b0);

    // T4: out-of-range reads and a dropped out-of-range write (aliases idx 0)
    rd(32'h1bff_fffc, FILL, 1'b1);
    rd(32'h1c01_0000, FILL, 1'b1);
    wr(32'h1c01_0000, 4'b1111, 32'h0000_0000);
    rd(BASE, 32'h11bb_11dd, 1'b0);

    // Loader vs bus write: same index loader wins, different indices both land
    drv(1'b1, 4'b1111, BASE + 32'h4, 32'hdead_beef, 1'b1, AW'(1), 32'h5555_5555);
    drv(1'b1, 4'b1111, BASE + 32'h18, 32'h6666_6666, 1'b1, AW'(7), 32'h7777_7777);
    rd(BASE + 32'h4, 32'h5555_5555, 1'b0);
    rd(BASE + 32'h18, 32'h6666_6666, 1'b0);
    rd(BASE + 32'h1c, 32'h7777_7777, 1'b0);

    // T5 (run part): loader write + bus read same index returns the old word
    drv(1'b1, 4'b0000, BASE + 32'h14, 32'd0, 1'b1, AW'(5), 32'hcafe_f00d);
    expect_rsp(FILL, 1'b0);
    rd(BASE + 32'h14, 32'hcafe_f00d, 1'b0);
    idle();
    idle();
    chk("hold_after_idle", rdata, 32'hcafe_f00d);

    // T6: reset mid-stream; the read issued with reset asserted gets no response
    ld(AW'(2), 32'h1234_5678);
    rd(BASE + 32'h8, 32'h1234_5678, 1'b0);
    drv(1'b1, 4'b0000, BASE + 32'hc, 32'd0, 1'b0, '0, 32'd0);
    rstn = 1'b0;
    idle();
    chk_reset_vals("midreset");
    rstn = 1'b1;

    // T5 (init part): requests and loader writes during the sweep are dropped
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) drv(1'b1, 4'b1111, BASE + 32'h2ee0, 32'hbad0_0000 + 32'(i), 1'b1,
                          AW'(5 + i * 100), 32'hbad1_0000 + 32'(i));
      else drv(1'b1, 4'b0000, BASE + 32'h8, 32'd0, 1'b1, AW'(5 + i * 100),
               32'hbad1_0000 + 32'(i));
    end
    en    = 1'b0;
    we    = 4'b0000;
    ld_en = 1'b0;
    repeat (DEPTH - 1 - 20) @(negedge clk);
    chk("reinit_done_early", 32'(init_done), 32'd0);
    @(negedge clk);
    chk("reinit_done_rise", 32'(init_done), 32'd1);
    rd(BASE + 32'h8, FILL, 1'b0);
    rd(BASE + 32'h14, FILL, 1'b0);
    rd(BASE + 32'(1905 * 4), FILL, 1'b0);
    rd(BASE + 32'h2ee0, FILL, 1'b0);
    rd(BASE, FILL, 1'b0);
    idle();
    idle();
    idle();
    chk("scoreboard_drained", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
